i4004_bus_sequencer: RTL and testbench
======================================

// Module: i4004_bus_sequencer
// PURPOSE
//  Sequences the shared 4-bit CPU data bus over the 8-phase instruction cycle (A1..X3).
//  Tracks the current phase from clk1/clk2 strobes and generates sync_pad.
//  Grants bus ownership per phase to the IP, scratchpad or ALU board, and controls pad direction.
//  Sits in i4004 between the timing strobes, the boards and the data_in/data_out/data_dir pads.
// PARAMETERS
//  RESET_PHASE  3'd7  phase loaded on reset; 7 = X3, so the first clk1 enters A1
// PORTS
//  sysclk     in   1  system clock; all state changes on posedge
//  poc_n      in   1  synchronous active-low reset
//  clk1       in   1  one-sysclk strobe marking the start of a phase
//  clk2       in   1  one-sysclk strobe marking mid-phase; bus sample/drive point
//  ip_data    in   4  address nibble from the IP board
//  sp_req     in   1  scratchpad requests bus in X2/X3 (SRC, FIM, ...)
//  sp_data    in   4  scratchpad nibble
//  alu_req    in   1  ALU requests bus in X2/X3 (WRM/WRR/IOW)
//  alu_data   in   4  ALU nibble
//  data_in    in   4  pad input
//  data_out   out  4  pad output nibble
//  data_dir   out  1  1 = pads driven
//  bus_data   out  4  internal bus value seen by all boards
//  phase      out  3  0=A1 1=A2 2=A3 3=M1 4=M2 5=X1 6=X2 7=X3
//  sync_pad   out  1  high while phase==X3 (combinational decode)
//  grant      out  3  one-hot {alu,sp,ip} current owner; 0 = pad input or idle
//  conflict   out  1  one-sysclk pulse: sp_req and alu_req both high at an X2/X3 clk2
//  proto_err  out  1  one-sysclk pulse: clk1 and clk2 high in the same sysclk
// BEHAVIOUR
//  Reset (poc_n=0 at posedge): phase=RESET_PHASE, data_out=0, data_dir=0, bus_data=0,
//   grant=0, conflict=0, proto_err=0; sync_pad follows phase (1 when RESET_PHASE=X3).
//   Reset mid-drive drops data_dir at that edge.
//  Phase advance: each clk1 strobe sets phase <= phase+1 mod 8 (X3 wraps to A1).
//  clk1 edge also clears data_dir and grant. This forces >=1 sysclk bus turnaround at every phase boundary.
//  Ownership is decided at the first clk2 strobe of a phase. Updates are registered (1 sysclk latency):
//   A1/A2/A3: grant=ip; data_out=ip_data; bus_data=ip_data; data_dir=1.
//   M1/M2: grant=0; data_dir=0; bus_data<=data_in (opcode/operand fetch).
//   X1: grant=0; data_dir=0; bus_data holds.
//   X2/X3: sp_req -> sp owns. Else alu_req -> alu owns. Owner's data goes to data_out/bus_data, data_dir=1.
//    Neither request -> grant=0, data_dir=0, bus_data<=data_in (RDM/RDR/IOR input).
//    Both requests -> sp wins and conflict pulses.
//  Only the first clk2 per phase counts; later clk2 strobes before the next clk1 are ignored (no error).
//  clk1 and clk2 in the same sysclk: clk1 processed, clk2 discarded, proto_err pulses.
//  Owner data is sampled once at clk2; changes to *_data mid-phase are not seen until the next phase.
//  No combinational path from any request to data_dir; all outputs except sync_pad are registered.
// STRUCTURE
//  i4004_pkg holds:
//   phase localparams PH_A1..PH_X3;
//   grant bit indices G_IP/G_SP/G_ALU;
//   helpers is_addr_phase(), is_exec_io_phase().
//  Sub-module i4004_phase_counter: clk1/clk2 strobes -> phase, sync_pad, first-clk2 qualifier, proto_err.
//  Arbitration and pad drive live in the top level.
// TESTING
//  1 Reset, then 8 clk1/clk2 pairs:
//    phase goes 7,0,1..7; sync_pad high only in X3; data_dir=0 until the first A1 clk2.
//  2 ip_data=4'hA in A1..A3:
//    data_out=A, grant=3'b001, data_dir=1 one sysclk after clk2; data_dir=0 one sysclk after the next clk1.
//  3 M1 with data_in=4'h5, no requests:
//    bus_data=5 after clk2, data_dir=0.
//  4 X2 with sp_req=1/sp_data=3 and alu_req=1/alu_data=C:
//    grant=3'b010, data_out=3, conflict pulses one cycle.
//  5 X3 with alu_req only, alu_data=9:
//    grant=3'b100, data_out=9. Then poc_n=0 mid-phase: data_dir=0 and phase=7 at that edge.
//  6 clk1 and clk2 in the same sysclk during M2:
//    phase advances to X1, proto_err pulses once, bus_data unchanged; a second clk2 in X1 is ignored.

Source files
------------

// File: rtl/i4004_bus_sequencer_pkg.sv
// Shared definitions for the i4004 bus sequencer.
//   - Phase encodings PH_A1..PH_X3 for the 8-phase instruction cycle.
//   - One-hot grant bit indices G_IP/G_SP/G_ALU.
//   - Bus owner enum plus helpers to classify phases and encode grants.
package i4004_bus_sequencer_pkg;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    localparam int unsigned G_IP  = 0;
    localparam int unsigned G_SP  = 1;
    localparam int unsigned G_ALU = 2;

    typedef enum logic [1:0] {
        OwnNone,
        OwnIp,
        OwnSp,
        OwnAlu
    } owner_e;

    // A1..A3: IP board drives the address nibbles.
    function automatic logic is_addr_phase(input logic [2:0] ph);
        return (ph == PH_A1) || (ph == PH_A2) || (ph == PH_A3);
    endfunction

    // M1/M2: opcode/operand fetched from the pads.
    function automatic logic is_fetch_phase(input logic [2:0] ph);
        return (ph == PH_M1) || (ph == PH_M2);
    endfunction

    // X2/X3: scratchpad or ALU may own the bus, otherwise pads are read.
    function automatic logic is_exec_io_phase(input logic [2:0] ph);
        return (ph == PH_X2) || (ph == PH_X3);
    endfunction

    function automatic logic [2:0] owner_grant(input owner_e own);
        logic [2:0] g;
        g = 3'b000;
        case (own)
            OwnIp:   g[G_IP]  = 1'b1;
            OwnSp:   g[G_SP]  = 1'b1;
            OwnAlu:  g[G_ALU] = 1'b1;
            default: g = 3'b000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/i4004_bus_sequencer_if.sv
// Board/pad side of the i4004 data bus.
//   master : the bus sequencer (drives pads, bus_data, grant, conflict)
//   slave  : the boards and pad cells (drive requests, owner nibbles, pad input)
// Signals:
//   ip_data, sp_req, sp_data, alu_req, alu_data : board requests and nibbles
//   data_in                                     : pad input nibble
//   data_out, data_dir                          : pad output nibble / drive enable
//   bus_data                                    : internal bus seen by all boards
//   grant                                       : one-hot {alu,sp,ip} owner
//   conflict                                    : sp/alu both requested in X2/X3
interface i4004_bus_sequencer_if;
    logic [3:0] ip_data;
    logic       sp_req;
    logic [3:0] sp_data;
    logic       alu_req;
    logic [3:0] alu_data;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_dir;
    logic [3:0] bus_data;
    logic [2:0] grant;
    logic       conflict;

    modport master (
        input  ip_data, sp_req, sp_data, alu_req, alu_data, data_in,
        output data_out, data_dir, bus_data, grant, conflict
    );

    modport slave (
        output ip_data, sp_req, sp_data, alu_req, alu_data, data_in,
        input  data_out, data_dir, bus_data, grant, conflict
    );
endinterface

// File: rtl/i4004_bus_sequencer_phase_counter.sv
// Phase tracker for the 8-phase instruction cycle.
// Ports:
//   sysclk     : system clock
//   poc_n      : synchronous active-low reset
//   clk1, clk2 : one-sysclk phase-start and mid-phase strobes
//   phase      : current phase (A1=0 .. X3=7), registered
//   sync_pad   : high while phase is X3 (decoded)
//   clk2_first : combinational qualifier, first valid clk2 of this phase
//   proto_err  : registered pulse when clk1 and clk2 coincide
module i4004_bus_sequencer_phase_counter
    import i4004_bus_sequencer_pkg::*;
#(
    parameter logic [2:0] RESET_PHASE = 3'd7
) (
    input  logic       sysclk,
    input  logic       poc_n,
    input  logic       clk1,
    input  logic       clk2,
    output logic [2:0] phase,
    output logic       sync_pad,
    output logic       clk2_first,
    output logic       proto_err
);

    logic [2:0] phase_q, phase_d;
    logic       clk2_seen_q, clk2_seen_d;
    logic       proto_err_q, proto_err_d;

    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            phase_q     <= RESET_PHASE;
            clk2_seen_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            clk2_seen_q <= clk2_seen_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        clk2_seen_d = clk2_seen_q;
        proto_err_d = clk1 & clk2;
        // clk1 wins a coincident strobe; the clk2 is discarded.
        clk2_first  = clk2 & ~clk1 & ~clk2_seen_q;

        if (clk1) begin
            phase_d     = phase_q + 3'd1;
            clk2_seen_d = 1'b0;
        end else if (clk2_first) begin
            clk2_seen_d = 1'b1;
        end
    end

    assign phase     = phase_q;
    assign sync_pad  = (phase_q == PH_X3);
    assign proto_err = proto_err_q;

endmodule

// File: rtl/i4004_bus_sequencer.sv
// Shared 4-bit data bus sequencer for the i4004.
// Tracks the instruction phase from clk1/clk2, grants the bus per phase to the
// IP, scratchpad or ALU board, and controls the pad drive direction.
// Ports:
//   sysclk     : system clock
//   poc_n      : synchronous active-low reset
//   clk1, clk2 : phase-start and mid-phase strobes
//   bus        : board/pad signals (master side)
//   phase      : current phase (A1=0 .. X3=7)
//   sync_pad   : high while phase is X3
//   proto_err  : pulse when clk1 and clk2 coincide
module i4004_bus_sequencer
    import i4004_bus_sequencer_pkg::*;
#(
    parameter logic [2:0] RESET_PHASE = 3'd7
) (
    input  logic                         sysclk,
    input  logic                         poc_n,
    input  logic                         clk1,
    input  logic                         clk2,
    i4004_bus_sequencer_if.master        bus,
    output logic [2:0]                   phase,
    output logic                         sync_pad,
    output logic                         proto_err
);

    logic       clk2_first;

    logic [3:0] data_out_q, data_out_d;
    logic       data_dir_q, data_dir_d;
    logic [3:0] bus_data_q, bus_data_d;
    logic [2:0] grant_q, grant_d;
    logic       conflict_q, conflict_d;
    owner_e     owner;

    i4004_bus_sequencer_phase_counter #(
        .RESET_PHASE (RESET_PHASE)
    ) u_phase_counter (
        .sysclk     (sysclk),
        .poc_n      (poc_n),
        .clk1       (clk1),
        .clk2       (clk2),
        .phase      (phase),
        .sync_pad   (sync_pad),
        .clk2_first (clk2_first),
        .proto_err  (proto_err)
    );

    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            data_out_q <= 4'h0;
            data_dir_q <= 1'b0;
            bus_data_q <= 4'h0;
            grant_q    <= 3'b000;
            conflict_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            data_dir_q <= data_dir_d;
            bus_data_q <= bus_data_d;
            grant_q    <= grant_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        data_dir_d = data_dir_q;
        bus_data_d = bus_data_q;
        grant_d    = grant_q;
        conflict_d = 1'b0;
        owner      = OwnNone;

        if (clk1) begin
            // Release the pads at every phase boundary so there is always
            // at least one sysclk of turnaround between drivers.
            data_dir_d = 1'b0;
            grant_d    = 3'b000;
        end else if (clk2_first) begin
            if (is_addr_phase(phase)) begin
                owner = OwnIp;
            end else if (is_exec_io_phase(phase)) begin
                if (bus.sp_req) begin
                    owner = OwnSp;
                end else if (bus.alu_req) begin
                    owner = OwnAlu;
                end
                conflict_d = bus.sp_req & bus.alu_req;
            end

            grant_d = owner_grant(owner);

            unique case (owner)
                OwnIp: begin
                    data_out_d = bus.ip_data;
                    bus_data_d = bus.ip_data;
                    data_dir_d = 1'b1;
                end
                OwnSp: begin
                    data_out_d = bus.sp_data;
                    bus_data_d = bus.sp_data;
                    data_dir_d = 1'b1;
                end
                OwnAlu: begin
                    data_out_d = bus.alu_data;
                    bus_data_d = bus.alu_data;
                    data_dir_d = 1'b1;
                end
                OwnNone: begin
                    data_dir_d = 1'b0;
                    // X1 keeps the previous bus value; fetch and undriven
                    // X2/X3 read the pads.
                    if (is_fetch_phase(phase) || is_exec_io_phase(phase)) begin
                        bus_data_d = bus.data_in;
                    end
                end
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.data_dir = data_dir_q;
    assign bus.bus_data = bus_data_q;
    assign bus.grant    = grant_q;
    assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_i4004_bus_sequencer.sv
module tb_i4004_bus_sequencer;

    typedef struct packed {
        logic [2:0] phase;
        logic       sync;
        logic [2:0] grant;
        logic       dir;
        logic [3:0] dout;
        logic [3:0] bus;
        logic       conflict;
        logic       perr;
    } exp_t;

    logic       sysclk;
    logic       poc_n;
    logic       clk1;
    logic       clk2;
    logic [2:0] phase;
    logic       sync_pad;
    logic       proto_err;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    i4004_bus_sequencer_if bus_if ();

    i4004_bus_sequencer #(
        .RESET_PHASE (3'd7)
    ) dut (
        .sysclk    (sysclk),
        .poc_n     (poc_n),
        .clk1      (clk1),
        .clk2      (clk2),
        .bus       (bus_if.master),
        .phase     (phase),
        .sync_pad  (sync_pad),
        .proto_err (proto_err)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    function automatic exp_t mk(input logic [2:0] ph, input logic [2:0] g, input logic d,
                                input logic [3:0] o, input logic [3:0] b, input logic cf,
                                input logic pe);
        exp_t r;
        r.phase    = ph;
        r.sync     = (ph == 3'd7);
        r.grant    = g;
        r.dir      = d;
        r.dout     = o;
        r.bus      = b;
        r.conflict = cf;
        r.perr     = pe;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every sysclk the DUT presents a fresh registered state; compare
    // it with the oldest outstanding expectation.
    always @(negedge sysclk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("phase",     {5'd0, phase},              {5'd0, mon_e.phase});
            chk("sync_pad",  {7'd0, sync_pad},           {7'd0, mon_e.sync});
            chk("grant",     {5'd0, bus_if.grant},       {5'd0, mon_e.grant});
            chk("data_dir",  {7'd0, bus_if.data_dir},    {7'd0, mon_e.dir});
            chk("data_out",  {4'd0, bus_if.data_out},    {4'd0, mon_e.dout});
            chk("bus_data",  {4'd0, bus_if.bus_data},    {4'd0, mon_e.bus});
            chk("conflict",  {7'd0, bus_if.conflict},    {7'd0, mon_e.conflict});
            chk("proto_err", {7'd0, proto_err},          {7'd0, mon_e.perr});
        end
    end

    // Drive strobes for one sysclk and queue the state expected after that edge.
    task automatic step(input logic c1, input logic c2, input exp_t e);
        clk1 = c1;
        clk2 = c2;
        @(posedge sysclk);
        exp_q.push_back(e);
        #1;
        clk1 = 1'b0;
        clk2 = 1'b0;
    endtask

    logic [2:0] gtab [8];
    logic       dtab [8];
    logic [3:0] btab [8];
    logic [3:0] prev_bus;

    initial begin
        poc_n            = 1'b0;
        clk1             = 1'b0;
        clk2             = 1'b0;
        bus_if.ip_data   = 4'h0;
        bus_if.sp_req    = 1'b0;
        bus_if.sp_data   = 4'h0;
        bus_if.alu_req   = 1'b0;
        bus_if.alu_data  = 4'h0;
        bus_if.data_in   = 4'h0;

        gtab = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        dtab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        // data_in = p+1 in each phase; X1 holds the M2 value.
        btab = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h5, 4'h5, 4'h7, 4'h8};

        // Reset state
        step(1'b0, 1'b0, mk(3'd7, 3'b000, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));
        step(1'b1, 1'b1, mk(3'd7, 3'b000, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));
        poc_n = 1'b1;

        // 1: walk all eight phases, ip_data=0, no requests
        prev_bus = 4'h0;
        for (int p = 0; p < 8; p++) begin
            step(1'b1, 1'b0, mk(3'(p), 3'b000, 1'b0, 4'h0, prev_bus, 1'b0, 1'b0));
            bus_if.data_in = 4'(p + 1);
            step(1'b0, 1'b1, mk(3'(p), gtab[p], dtab[p], 4'h0, btab[p], 1'b0, 1'b0));
            prev_bus = btab[p];
        end

        // 2: IP address phases with ip_data=A
        bus_if.ip_data = 4'hA;
        step(1'b1, 1'b0, mk(3'd0, 3'b000, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0));
        step(1'b0, 1'b1, mk(3'd0, 3'b001, 1'b1, 4'hA, 4'hA, 1'b0, 1'b0));
        step(1'b0, 1'b0, mk(3'd0, 3'b001, 1'b1, 4'hA, 4'hA, 1'b0, 1'b0));
        bus_if.ip_data = 4'hF;  // mid-phase change and repeat clk2: not seen
        step(1'b0, 1'b1, mk(3'd0, 3'b001, 1'b1, 4'hA, 4'hA, 1'b0, 1'b0));
        bus_if.ip_data = 4'hA;
        step(1'b1, 1'b0, mk(3'd1, 3'b000, 1'b0, 4'hA, 4'hA, 1'b0, 1'b0));
        step(1'b0, 1'b1, mk(3'd1, 3'b001, 1'b1, 4'hA, 4'hA, 1'b0, 1'b0));
        step(1'b1, 1'b0, mk(3'd2, 3'b000, 1'b0, 4'hA, 4'hA, 1'b0, 1'b0));
        step(1'b0, 1'b1, mk(3'd2, 3'b001, 1'b1, 4'hA, 4'hA, 1'b0, 1'b0));

        // 3: M1 fetch of data_in=5
        bus_if.data_in = 4'h5;
        step(1'b1, 1'b0, mk(3'd3, 3'b000, 1'b0, 4'hA, 4'hA, 1'b0, 1'b0));
        step(1'b0, 1'b1, mk(3'd3, 3'b000, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0));

        // 6: coincident strobes during M2
        step(1'b1, 1'b0, mk(3'd4, 3'b000, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0));
        bus_if.data_in = 4'h6;
        step(1'b0, 1'b1, mk(3'd4, 3'b000, 1'b0, 4'hA, 4'h6, 1'b0, 1'b0));
        bus_if.data_in = 4'h7;
        step(1'b1, 1'b1, mk(3'd5, 3'b000, 1'b0, 4'hA, 4'h6, 1'b0, 1'b1));
        step(1'b0, 1'b0, mk(3'd5, 3'b000, 1'b0, 4'hA, 4'h6, 1'b0, 1'b0));
        step(1'b0, 1'b1, mk(3'd5, 3'b000, 1'b0, 4'hA, 4'h6, 1'b0, 1'b0));
        step(1'b0, 1'b1, mk(3'd5, 3'b000, 1'b0, 4'hA, 4'h6, 1'b0, 1'b0));

        // 4: X2 with both requests, sp wins
        step(1'b1, 1'b0, mk(3'd6, 3'b000, 1'b0, 4'hA, 4'h6, 1'b0, 1'b0));
        bus_if.sp_req   = 1'b1;
        bus_if.sp_data  = 4'h3;
        bus_if.alu_req  = 1'b1;
        bus_if.alu_data = 4'hC;
        step(1'b0, 1'b1, mk(3'd6, 3'b010, 1'b1, 4'h3, 4'h3, 1'b1, 1'b0));
        step(1'b0, 1'b0, mk(3'd6, 3'b010, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0));
        step(1'b0, 1'b1, mk(3'd6, 3'b010, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0));

        // 5: X3 with ALU only, then reset mid-drive
        bus_if.sp_req   = 1'b0;
        bus_if.alu_data = 4'h9;
        step(1'b1, 1'b0, mk(3'd7, 3'b000, 1'b0, 4'h3, 4'h3, 1'b0, 1'b0));
        step(1'b0, 1'b1, mk(3'd7, 3'b100, 1'b1, 4'h9, 4'h9, 1'b0, 1'b0));
        step(1'b0, 1'b0, mk(3'd7, 3'b100, 1'b1, 4'h9, 4'h9, 1'b0, 1'b0));
        poc_n = 1'b0;
        step(1'b0, 1'b0, mk(3'd7, 3'b000, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));
        poc_n = 1'b1;
        bus_if.alu_req = 1'b0;
        step(1'b0, 1'b0, mk(3'd7, 3'b000, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));

        // Let the monitor drain the last expectation.
        @(negedge sysclk);
        #1;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
